// File: rtl/mult_datapath_if.sv
// Bundle between the multiplier control unit (master) and the shift-add datapath (slave).
// MULT_DP_STEP_CNT_EN adds the step_cnt observation signal.
interface mult_datapath_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic signed [WIDTH-1:0]   multiplicand;
    logic signed [WIDTH-1:0]   multiplier;
    logic                      reg_en;
    logic                      load;
    logic                      shift_en;
    logic                      psel;
    logic                      z_flag_multiplier;
    logic        [2*WIDTH-1:0] product;
`ifdef MULT_DP_STEP_CNT_EN
    logic        [CNT_W-1:0]   step_cnt;

    modport master (
        output multiplicand, multiplier, reg_en, load, shift_en, psel,
        input  z_flag_multiplier, product, step_cnt
    );

    modport slave (
        input  multiplicand, multiplier, reg_en, load, shift_en, psel,
        output z_flag_multiplier, product, step_cnt
    );
`else
    modport master (
        output multiplicand, multiplier, reg_en, load, shift_en, psel,
        input  z_flag_multiplier, product
    );

    modport slave (
        input  multiplicand, multiplier, reg_en, load, shift_en, psel,
        output z_flag_multiplier, product
    );
`endif
endinterface

// File: rtl/mult_datapath.sv
// Sign-magnitude shift-add datapath of the sequential signed multiplier.
// Optional MULT_DP_STEP_CNT_EN exposes a count of effective steps since load.
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_datapath_if.slave   bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand_mag;
    logic [WIDTH-1:0] mplier_mag;
    logic [PW-1:0]    acc;
    logic             sign;

    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             mplier_zero;
    logic             do_load;
    logic             do_step;

    // Two's-complement negate of the most-negative value yields 2^(WIDTH-1), correct as unsigned.
    always_comb begin
        a_raw       = bus.multiplicand;
        b_raw       = bus.multiplier;
        a_abs       = a_raw[WIDTH-1] ? (~a_raw + WIDTH'(1)) : a_raw;
        b_abs       = b_raw[WIDTH-1] ? (~b_raw + WIDTH'(1)) : b_raw;
        mplier_zero = (mplier_magnitude_is_zero(mplier_mag));
        do_load     = bus.reg_en & bus.load;
        do_step     = bus.reg_en & ~bus.load & bus.shift_en & ~mplier_zero;
    end

    function automatic logic mplier_magnitude_is_zero(input logic [WIDTH-1:0] m);
        return (m == '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_mag  <= '0;
            mplier_mag <= '0;
            acc        <= '0;
            sign       <= 1'b0;
        end else if (do_load) begin
            mcand_mag  <= {{WIDTH{1'b0}}, a_abs};
            mplier_mag <= b_abs;
            acc        <= '0;
            sign       <= a_raw[WIDTH-1] ^ b_raw[WIDTH-1];
        end else if (do_step) begin
            if (mplier_mag[0]) begin
                acc <= acc + mcand_mag;
            end
            mcand_mag  <= {mcand_mag[PW-2:0], 1'b0};
            mplier_mag <= {1'b0, mplier_mag[WIDTH-1:1]};
        end
    end

`ifdef MULT_DP_STEP_CNT_EN
    logic [CNT_W-1:0] step_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
        end else if (do_load) begin
            step_cnt_q <= '0;
        end else if (do_step) begin
            step_cnt_q <= step_cnt_q + CNT_W'(1);
        end
    end

    assign bus.step_cnt = step_cnt_q;
`endif

    // A zero accumulator negates to zero, so no separate -0 handling is needed.
    always_comb begin
        bus.z_flag_multiplier = mplier_zero;
        bus.product           = '0;
        if (bus.psel) begin
            bus.product = sign ? (~acc + PW'(1)) : acc;
        end
    end
endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: directed cases plus randomized operand runs.
// Expected products and step counts come from plain signed arithmetic.
module tb_mult_datapath;
    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;

    typedef struct {
        logic [PW-1:0] prod;
        int unsigned   k;
    } exp_t;

    logic clk;
    logic rst_n;
    logic check_req;
    int unsigned obs_steps;
    int unsigned checks;
    int unsigned failures;
    exp_t sb[$];

    mult_datapath_if #(.WIDTH(WIDTH)) bus();

    mult_datapath #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned bit_len(input logic signed [WIDTH-1:0] b);
        int v;
        int unsigned n;
        v = int'(b);
        if (v < 0) v = -v;
        n = 0;
        while (v != 0) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    // Monitor: one pop per completion strobe raised by the stimulus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (check_req) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", 32'(bus.product), 32'(e.prod));
                    check("z_flag", 32'(bus.z_flag_multiplier), 32'd1);
                    check("latency_steps", obs_steps, e.k);
`ifdef MULT_DP_STEP_CNT_EN
                    check("step_cnt", 32'(bus.step_cnt), e.k);
`endif
                end
            end
        end
    end

    task automatic drive_load(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                              input logic with_shift);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.reg_en       = 1'b1;
        bus.load         = 1'b1;
        bus.shift_en     = with_shift;
        @(negedge clk);
        bus.load         = 1'b0;
        bus.shift_en     = 1'b0;
    endtask

    task automatic run_op(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                          input logic pre, input logic signed [WIDTH-1:0] pa,
                          input logic signed [WIDTH-1:0] pb, input int unsigned extra);
        exp_t e;
        int unsigned steps;
        int unsigned cyc;
        if (pre) begin
            drive_load(pa, pb, 1'b0);
            bus.shift_en = 1'b1;
            repeat (2) @(negedge clk);
        end
        e.prod = PW'(int'(a) * int'(b));
        e.k    = bit_len(b);
        sb.push_back(e);
        drive_load(a, b, pre);
        if (!pre) check("load_clears_acc", 32'(bus.product), 32'd0);
        steps = 0;
        cyc   = 0;
        while (!bus.z_flag_multiplier && cyc < 40) begin
            cyc++;
            bus.shift_en = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                bus.reg_en = 1'b0;
            end else begin
                bus.reg_en = 1'b1;
                steps++;
            end
            @(negedge clk);
        end
        bus.reg_en   = 1'b1;
        bus.shift_en = 1'b0;
        if (!bus.z_flag_multiplier) check("z_flag_timeout", 32'd0, 32'd1);
        repeat (extra) begin
            bus.shift_en = 1'b1;
            @(negedge clk);
        end
        bus.shift_en = 1'b0;
        obs_steps = steps;
        check_req = 1'b1;
        @(negedge clk);
        check_req = 1'b0;
    endtask

    initial begin
        logic signed [WIDTH-1:0] ra;
        logic signed [WIDTH-1:0] rb;
        checks = 0;
        failures = 0;
        check_req = 1'b0;
        obs_steps = 0;
        rst_n = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.reg_en       = 1'b0;
        bus.load         = 1'b0;
        bus.shift_en     = 1'b0;
        bus.psel         = 1'b1;
        #3;
        check("reset_product", 32'(bus.product), 32'd0);
        check("reset_z", 32'(bus.z_flag_multiplier), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_z", 32'(bus.z_flag_multiplier), 32'd1);

        run_op(8'sd7, -8'sd3, 1'b0, '0, '0, 0);
        run_op(-8'sd128, -8'sd128, 1'b0, '0, '0, 0);
        run_op(8'sd127, -8'sd128, 1'b0, '0, '0, 1);
        run_op(8'sh55, 8'sd0, 1'b0, '0, '0, 5);
        run_op(8'sd2, 8'sd3, 1'b1, 8'sd100, -8'sd77, 0);
        run_op(8'sd5, 8'sd100, 1'b0, '0, '0, 2);

        // Hold: one step of 7 x -3 leaves acc=7, sign negative; reg_en low must freeze it.
        drive_load(8'sd7, -8'sd3, 1'b0);
        bus.shift_en = 1'b1;
        @(negedge clk);
        check("one_step_partial", 32'(bus.product), 32'h0000FFF9);
        bus.reg_en = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_product", 32'(bus.product), 32'h0000FFF9);
        check("hold_z", 32'(bus.z_flag_multiplier), 32'd0);
        bus.reg_en   = 1'b1;
        bus.shift_en = 1'b0;
        bus.psel     = 1'b0;
        #1;
        check("psel_zero", 32'(bus.product), 32'd0);
        bus.psel = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset_product", 32'(bus.product), 32'd0);
        check("midop_reset_z", 32'(bus.z_flag_multiplier), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op(ra, rb, ($urandom_range(0, 3) == 0), WIDTH'($urandom), WIDTH'($urandom),
                   $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Datapath half of the sequential signed multiplier: the responder to the control unit's load/reg_en/shift_en/psel strobes.
- Latches two signed operands, converts them to sign-magnitude, and runs an unsigned shift-add loop one step per enabled cycle.
- Drives z_flag_multiplier back to the controller and presents the sign-corrected 2*WIDTH product to the display logic.

Parameters:
WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
multiplicand  input  WIDTH  signed operand A, sampled on load
multiplier  input  WIDTH  signed operand B, sampled on load
reg_en  input  1  register enable; when low all internal registers hold
load  input  1  load operands (qualified by reg_en)
shift_en  input  1  perform one shift-add step (qualified by reg_en)
psel  input  1  product output select: 1 = result, 0 = zero
z_flag_multiplier  output  1  high when remaining multiplier magnitude is zero
product  output  2*WIDTH  signed product, two's complement

Behaviour:
- Internal registers: mcand_mag (2*WIDTH, unsigned), mplier_mag (WIDTH, unsigned), acc (2*WIDTH, unsigned), sign (1).
- Reset (rst_n low, asynchronous): all registers 0. Hence z_flag_multiplier=1 and product=0 during and after reset until the next load.
- Priority per rising edge: reg_en=0 -> hold; reg_en=1 & load=1 -> load (shift_en ignored); reg_en=1 & load=0 & shift_en=1 -> step; otherwise hold.
- Load:
  - mcand_mag <= zero-extended |multiplicand|.
  - mplier_mag <= |multiplier|.
  - acc <= 0.
  - sign <= multiplicand[WIDTH-1] XOR multiplier[WIDTH-1].
  - Magnitude of the most-negative value (-2^(WIDTH-1)) is 2^(WIDTH-1), which fits unsigned in WIDTH bits; no overflow.
- Step, with mplier_mag != 0:
  - If mplier_mag[0]=1: acc <= acc + mcand_mag (2*WIDTH-bit, no carry-out possible).
  - Always: mcand_mag <= mcand_mag << 1 and mplier_mag <= mplier_mag >> 1.
- Step with mplier_mag == 0: no register changes (idempotent). The controller may issue extra shift cycles safely.
- z_flag_multiplier = (mplier_mag == 0), combinational from the register; no added latency.
- Latency after load:
  - z_flag_multiplier rises after k steps, where k = bit position of the MSB of |multiplier| plus 1; k <= WIDTH.
  - When the multiplier is 0, z_flag_multiplier is high in the cycle after load.
- product (combinational from registers):
  - psel=1: product = sign ? -acc : acc, 2*WIDTH two's complement.
  - psel=0: product = 0.
  - Zero result yields 0 regardless of sign; -0 is not a distinct value.
- Intermediate product values during stepping are partial sums. They are only meaningful once z_flag_multiplier=1.
- Re-load mid-operation (load while stepping): the new operands replace all state in one cycle; no residue from the prior run.
- Reset mid-operation: immediate return to the reset state.

Optional Feature:
- Macro MULT_DP_STEP_CNT_EN.
- Defined:
  - Adds output port step_cnt, width $clog2(WIDTH+1).
  - Counts effective steps, i.e. shift cycles with mplier_mag != 0, since the last load.
  - Cleared by reset and by load; holds when reg_en=0 or z_flag_multiplier=1.
  - Maximum value is WIDTH.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with psel=1 -> product=16'h0000 and z_flag_multiplier=1 immediately, with no clock edge needed.
- WIDTH=8, load 7 x -3, then shift until z_flag:
  - z_flag rises after 2 steps.
  - psel=1 -> product=16'hFFEB (-21).
- Load -128 x -128 -> z_flag after 8 steps, product=16'h4000 (16384). Load 127 x -128 -> product=16'hC080 (-16256).
- Load 0x55 x 0:
  - z_flag=1 in the cycle after load and product=0.
  - 5 further shift cycles leave acc unchanged.
  - With the macro defined, step_cnt=0.
- Hold and priority:
  - reg_en=0 with shift_en=1 for 3 cycles -> registers unchanged.
  - load=1 and shift_en=1 together -> only the load occurs (acc=0).
  - A mid-run re-load of 2 x 3 -> product=6.
- With MULT_DP_STEP_CNT_EN, load 5 x 100 (0b1100100) -> step_cnt=7 at z_flag; product=500.
